// File: rtl/line_buf_writer_pkg.sv
// Shared CNN parameters: default image geometry, pixel depth and line-RAM bank count.
package line_buf_writer_pkg;

  localparam int unsigned BIT_DEPTH    = 8;
  localparam int unsigned IMAGE_WIDTH  = 28;
  localparam int unsigned IMAGE_HEIGHT = 28;
  localparam int unsigned NUM_BANKS    = 4;
  localparam int unsigned ADDR_W       = 11;
  localparam int unsigned LV_W         = 3;

  typedef enum logic [1:0] {
    BANK0 = 2'd0,
    BANK1 = 2'd1,
    BANK2 = 2'd2,
    BANK3 = 2'd3
  } bank_e;

  // Frame row k lands in bank (k+1) mod 4.
  function automatic bank_e row_bank(input logic [1:0] row_lsb);
    return bank_e'(row_lsb + 2'd1);
  endfunction

endpackage

// File: rtl/line_buf_writer.sv
// Line-buffer writer: steers incoming pixels into four rotating line-RAM banks,
// tracks resident rows for the conv reader and flags reader protocol errors.
module line_buf_writer
  import line_buf_writer_pkg::*;
#(
  parameter int unsigned bit_depth    = BIT_DEPTH,
  parameter int unsigned image_width  = IMAGE_WIDTH,
  parameter int unsigned image_height = IMAGE_HEIGHT
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   de_in,
  input  logic [bit_depth*3-1:0] pix_in,
  output logic                   ready_out,
  output logic [10:0]            wr_addr,
  output logic [bit_depth*3-1:0] wr_data,
  output logic                   in0_wren,
  output logic                   in1_wren,
  output logic                   in2_wren,
  output logic                   in3_wren,
  output logic                   start_rd,
  input  logic                   fin_rd,
  output logic                   frame_done,
  output logic                   err
);

  localparam int unsigned COL_W = (image_width > 1) ? $clog2(image_width) : 1;
  localparam int unsigned ROW_W = (image_height > 4) ? $clog2(image_height) : 2;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(image_width - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(image_height - 1);
  localparam logic [ROW_W-1:0] RD_END   = ROW_W'(image_height - 2);
  localparam logic [LV_W-1:0]  LV_FULL  = LV_W'(NUM_BANKS);
  localparam logic [LV_W-1:0]  LV_START = LV_W'(3);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] rd_cnt;
  logic [LV_W-1:0]  lines_valid;
  logic             drain;

  logic             accept;
  logic             row_done;
  logic             fin_ok;
  logic             fin_bad;
  logic             frame_end;
  bank_e            bank;
  logic [3:0]       bank_onehot;
  logic [3:0]       wren_q;

  // Handshake, event decode and bank selection for the current row.
  always_comb begin
    ready_out   = (lines_valid != LV_FULL) && !drain;
    accept      = de_in && ready_out;
    row_done    = accept && (col == COL_LAST);
    fin_ok      = fin_rd && (lines_valid >= LV_START);
    fin_bad     = fin_rd && (lines_valid < LV_START);
    frame_end   = (rd_cnt == RD_END);
    bank        = row_bank(row[1:0]);
    bank_onehot = '0;
    unique case (bank)
      BANK0: bank_onehot = 4'b0001;
      BANK1: bank_onehot = 4'b0010;
      BANK2: bank_onehot = 4'b0100;
      BANK3: bank_onehot = 4'b1000;
    endcase
  end

  // Column/row position, resident-row count, read count and drain flag.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      col         <= '0;
      row         <= '0;
      rd_cnt      <= '0;
      lines_valid <= '0;
      drain       <= 1'b0;
    end else if (frame_end) begin
      col         <= '0;
      row         <= '0;
      rd_cnt      <= '0;
      lines_valid <= '0;
      drain       <= 1'b0;
    end else begin
      if (accept) begin
        col <= row_done ? '0 : col + 1'b1;
      end
      if (row_done) begin
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        if (row == ROW_LAST) begin
          drain <= 1'b1;
        end
      end
      // A row arriving and a row retiring in the same cycle cancel out.
      unique case ({row_done, fin_ok})
        2'b10:   lines_valid <= lines_valid + 1'b1;
        2'b01:   lines_valid <= lines_valid - 1'b1;
        default: lines_valid <= lines_valid;
      endcase
      if (fin_ok) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Registered line-RAM write port; address and data hold when idle.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_addr <= '0;
      wr_data <= '0;
      wren_q  <= '0;
    end else if (accept) begin
      wr_addr <= ADDR_W'(col);
      wr_data <= pix_in;
      wren_q  <= bank_onehot;
    end else begin
      wren_q  <= '0;
    end
  end

  // Registered reader start level, end-of-frame pulse and sticky error.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      start_rd   <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      start_rd   <= (lines_valid >= LV_START) && (rd_cnt < RD_END);
      frame_done <= frame_end;
      err        <= err | fin_bad;
    end
  end

  assign in0_wren = wren_q[0];
  assign in1_wren = wren_q[1];
  assign in2_wren = wren_q[2];
  assign in3_wren = wren_q[3];

endmodule

// File: tb/tb_line_buf_writer.sv
// Directed bench for line_buf_writer at default geometry (28x28, 24-bit pixels).
module tb_line_buf_writer;

  logic        clk;
  logic        RESET;
  logic        de_in;
  logic [23:0] pix_in;
  logic        ready_out;
  logic [10:0] wr_addr;
  logic [23:0] wr_data;
  logic        in0_wren, in1_wren, in2_wren, in3_wren;
  logic        start_rd;
  logic        fin_rd;
  logic        frame_done;
  logic        err;
  logic [3:0]  wren_v;

  int n_total;
  int n_bad;

  line_buf_writer #(
    .bit_depth   (8),
    .image_width (28),
    .image_height(28)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .de_in     (de_in),
    .pix_in    (pix_in),
    .ready_out (ready_out),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .in0_wren  (in0_wren),
    .in1_wren  (in1_wren),
    .in2_wren  (in2_wren),
    .in3_wren  (in3_wren),
    .start_rd  (start_rd),
    .fin_rd    (fin_rd),
    .frame_done(frame_done),
    .err       (err)
  );

  assign wren_v = {in3_wren, in2_wren, in1_wren, in0_wren};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pv(input int r, input int c);
    logic [7:0] rr;
    logic [7:0] cc;
    rr = 8'(r);
    cc = 8'(c);
    return {rr, cc, cc ^ 8'h5a};
  endfunction

  function automatic logic [3:0] bank_mask(input int r);
    return 4'b0001 << ((r + 1) % 4);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [23:0] pix, input logic fin,
                      input logic [3:0] exp_mask, input logic [10:0] exp_addr);
    de_in  = 1'b1;
    pix_in = pix;
    fin_rd = fin;
    step();
    de_in  = 1'b0;
    fin_rd = 1'b0;
    check_val({tag, "_wren"}, 32'(wren_v), 32'(exp_mask));
    check_val({tag, "_addr"}, 32'(wr_addr), 32'(exp_addr));
    check_val({tag, "_data"}, 32'(wr_data), 32'(pix));
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 32'(ready_out), 32'd1);
    check_val({tag, "_wren"},  32'(wren_v),    32'd0);
    check_val({tag, "_addr"},  32'(wr_addr),   32'd0);
    check_val({tag, "_data"},  32'(wr_data),   32'd0);
    check_val({tag, "_start"}, 32'(start_rd),  32'd0);
    check_val({tag, "_fdone"}, 32'(frame_done),32'd0);
    check_val({tag, "_err"},   32'(err),       32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m_lv, m_rows, m_rd, m_col, cyc, fd_seen;
    logic m_drain, m_ready, do_acc, do_fin, exp_start, row_end;

    n_total = 0;
    n_bad   = 0;
    RESET   = 1'b1;
    de_in   = 1'b0;
    pix_in  = '0;
    fin_rd  = 1'b0;

    // Reset state, seen asynchronously before any clock edge and after release.
    #2;
    check_reset_outputs("rst_async");
    do_reset();
    check_reset_outputs("rst");

    // Three ramp rows: banks 1, 2, 3 at addr 0..27; start_rd one cycle late.
    for (int i = 0; i < 84; i++) begin
      check_val("r3_ready", 32'(ready_out), 32'd1);
      push("r3", pv(i / 28, i % 28), 1'b0, bank_mask(i / 28), 11'(i % 28));
      check_val("r3_start_lo", 32'(start_rd), 32'd0);
    end
    step();
    check_val("r3_start_hi", 32'(start_rd), 32'd1);
    check_val("r3_idle_wren", 32'(wren_v), 32'd0);
    check_val("r3_hold_addr", 32'(wr_addr), 32'd27);
    check_val("r3_hold_data", 32'(wr_data), 32'(pv(2, 27)));

    // Row 3 into bank 0 with fin_rd on its last pixel: count stays at 3.
    for (int c = 0; c < 28; c++) begin
      push("co", pv(3, c), (c == 27), 4'b0001, 11'(c));
      check_val("co_start", 32'(start_rd), 32'd1);
    end
    step();
    check_val("co_ready", 32'(ready_out), 32'd1);
    check_val("co_start_after", 32'(start_rd), 32'd1);

    // Row 4 without fin_rd fills all four banks; writer must stall.
    for (int c = 0; c < 28; c++) begin
      push("full", pv(4, c), 1'b0, 4'b0010, 11'(c));
    end
    check_val("full_ready_lo", 32'(ready_out), 32'd0);
    de_in  = 1'b1;
    pix_in = 24'hABCDEF;
    step();
    de_in  = 1'b0;
    check_val("full_drop_wren", 32'(wren_v), 32'd0);
    check_val("full_drop_addr", 32'(wr_addr), 32'd27);
    check_val("full_drop_data", 32'(wr_data), 32'(pv(4, 27)));
    check_val("full_err", 32'(err), 32'd0);
    fin_rd = 1'b1;
    step();
    fin_rd = 1'b0;
    check_val("full_ready_back", 32'(ready_out), 32'd1);
    check_val("full_start", 32'(start_rd), 32'd1);

    // Full frame from reset, reader retiring rows whenever the buffer is full.
    do_reset();
    m_lv = 0; m_rows = 0; m_rd = 0; m_col = 0; m_drain = 1'b0; cyc = 0; fd_seen = 0;
    while (m_rd < 26 && cyc < 3000) begin
      m_ready   = (m_lv != 4) && !m_drain;
      check_val("frm_ready", 32'(ready_out), 32'(m_ready));
      do_acc    = m_ready && (m_rows < 28);
      do_fin    = (m_rd < 26) && ((m_lv == 4) || (m_rows == 28 && m_lv >= 3));
      exp_start = (m_lv >= 3) && (m_rd < 26);
      de_in  = (m_rows < 28);
      pix_in = pv(m_rows, m_col);
      fin_rd = do_fin;
      step();
      if (do_acc) begin
        check_val("frm_wren", 32'(wren_v), 32'(bank_mask(m_rows)));
        check_val("frm_addr", 32'(wr_addr), 32'(m_col));
      end else begin
        check_val("frm_nowren", 32'(wren_v), 32'd0);
      end
      check_val("frm_start", 32'(start_rd), 32'(exp_start));
      fd_seen += int'(frame_done);
      row_end = do_acc && (m_col == 27);
      if (do_acc) m_col = row_end ? 0 : m_col + 1;
      if (row_end) m_rows++;
      if (m_rows == 28) m_drain = 1'b1;
      m_lv = m_lv + int'(row_end) - int'(do_fin);
      if (do_fin) m_rd++;
      cyc++;
    end
    de_in  = 1'b0;
    fin_rd = 1'b0;
    check_val("frm_in_budget", 32'(cyc < 3000), 32'd1);
    check_val("frm_no_early_done", 32'(fd_seen), 32'd0);
    check_val("frm_done_lo", 32'(frame_done), 32'd0);
    step();
    check_val("frm_done_pulse", 32'(frame_done), 32'd1);
    check_val("frm_ready_clr", 32'(ready_out), 32'd1);
    check_val("frm_start_clr", 32'(start_rd), 32'd0);
    step();
    check_val("frm_done_end", 32'(frame_done), 32'd0);
    push("nf", pv(0, 0), 1'b0, 4'b0010, 11'd0);
    check_val("frm_err", 32'(err), 32'd0);

    // fin_rd with only two rows resident: error, counters untouched.
    do_reset();
    for (int i = 0; i < 56; i++) begin
      push("e2", pv(i / 28, i % 28), 1'b0, bank_mask(i / 28), 11'(i % 28));
    end
    check_val("e_err_pre", 32'(err), 32'd0);
    fin_rd = 1'b1;
    step();
    fin_rd = 1'b0;
    check_val("e_err_set", 32'(err), 32'd1);
    for (int c = 0; c < 28; c++) begin
      push("e_row2", pv(2, c), 1'b0, 4'b1000, 11'(c));
    end
    step();
    check_val("e_start", 32'(start_rd), 32'd1);
    check_val("e_err_sticky", 32'(err), 32'd1);
    for (int c = 0; c < 13; c++) begin
      push("e_row3", pv(3, c), 1'b0, 4'b0001, 11'(c));
    end

    // Asynchronous reset mid-row (col=13).
    #2;
    RESET = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    RESET = 1'b0;
    push("post_rst", pv(0, 0), 1'b0, 4'b0010, 11'd0);
    check_val("post_rst_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/line_buf_writer.md
LINE_BUF_WRITER -- requirements
Module: line_buf_writer

Interface
REQ-001 Parameter bit_depth, default 8: bits per colour channel; a pixel is 3 channels, bit_depth*3 bits.
REQ-002 Parameter image_width, default 28: pixels per row.
REQ-003 Parameter image_height, default 28: rows per frame.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 de_in  in  1  pixel valid from upstream.
REQ-007 pix_in  in  bit_depth*3  pixel data, channel a in MSBs.
REQ-008 ready_out  out  1  writer can accept a pixel this cycle.
REQ-009 wr_addr  out  11  line-RAM write address (column).
REQ-010 wr_data  out  bit_depth*3  line-RAM write data.
REQ-011 in0_wren, in1_wren, in2_wren, in3_wren  out  1 each  per-bank write enables.
REQ-012 start_rd  out  1  level; at least 3 complete rows are resident, so the conv reader may run.
REQ-013 fin_rd  in  1  one-cycle pulse from the conv reader: one output row has been read.
REQ-014 frame_done  out  1  one-cycle pulse at the end of a frame.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 A pixel is accepted on any cycle with de_in && ready_out; pixels offered while ready_out=0 are dropped and do not set err.
REQ-017 Counter col runs 0..image_width-1 and increments per accepted pixel, wrapping to 0 after image_width-1.
REQ-018 Counter row runs 0..image_height-1 and increments when the pixel at col=image_width-1 is accepted.
REQ-019 Frame row k is written to bank (k+1) mod 4: row 0 to bank 1, row 3 to bank 0.
REQ-020 Write latency is 1 cycle: the cycle after acceptance, wr_addr=col, wr_data=pix_in and exactly one inN_wren is high.
REQ-021 With no accepted pixel, all wren signals are low and wr_addr/wr_data hold their previous values.
REQ-022 Counter lines_valid (0..4) increments on row completion (last-column acceptance) and decrements on fin_rd.
REQ-023 Row completion and fin_rd in the same cycle leave lines_valid unchanged.
REQ-024 ready_out = (lines_valid != 4) && !drain, where drain is set once row image_height-1 completes.
REQ-025 start_rd is registered; it is high while lines_valid >= 3 and rd_cnt < image_height-2, where rd_cnt counts fin_rd pulses in the frame.
REQ-026 A fin_rd arriving while lines_valid < 3 is ignored for all counters and sets err.
REQ-027 When rd_cnt reaches image_height-2, frame_done pulses on the next cycle, and in that same cycle col, row, lines_valid, rd_cnt and drain clear to 0.
REQ-028 frame_done and err have 1-cycle registered latency from their cause.

Reset
REQ-029 RESET asynchronously forces col=0, row=0, lines_valid=0, rd_cnt=0, drain=0.
REQ-030 RESET asynchronously forces wr_addr=0, wr_data=0, all wren=0, start_rd=0, frame_done=0, err=0.
REQ-031 RESET forces ready_out=1 combinationally while deasserted state is 0.
REQ-032 RESET mid-frame abandons the frame; RAM contents are not cleared.
REQ-033 err clears only on RESET.

Structure
REQ-034 bit_depth, image_width and image_height defaults, and the 4-bank count, live in the shared CNN parameter package used by conv_layer.
REQ-035 The block is a single module with no sub-modules; counters and flags are inline.

Verification
REQ-036 Continuous de_in, 3 rows of ramp pixels (value = col) -> bank1 then 2 then 3 written at addr 0..27; start_rd rises 1 cycle after pixel 84 is written; ready_out stays 1.
REQ-037 4 rows written with no fin_rd -> lines_valid=4; ready_out=0 on the cycle after the row-3 completion; a pixel offered then causes no wren; one fin_rd restores ready_out=1 the next cycle.
REQ-038 Row completion coincident with fin_rd, lines_valid=3 -> lines_valid stays 3, start_rd stays 1.
REQ-039 Full 28x28 frame with 26 fin_rd pulses -> frame_done pulses once, counters return to 0, and the next frame's row 0 writes bank 1.
REQ-040 fin_rd issued at lines_valid=2 -> err=1 and counters unchanged; RESET mid-row (col=13) -> all outputs at reset values immediately, and the next pixel writes bank 1, addr 0.
